// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, reset PC,
// opcode constants, the fetch FSM encoding and the JAL immediate decoder.
package if_fetch_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic [InstAddrBus-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [6:0]             Opcode_jal       = 7'b1101111;
    localparam logic [InstBus-1:0]     NOP_INST         = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_e;

    // Sign-extended J-type immediate (byte offset, bit 0 always zero).
    function automatic logic [InstAddrBus-1:0] jal_imm(input logic [InstBus-1:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/if_predecode.sv
// Combinational JAL detector: flags a JAL word and computes its target from
// the address it was fetched from. Only instantiated under IF_JAL_PREDICT_EN.
module if_predecode
    import if_fetch_pkg::*;
(
    input  logic [InstBus-1:0]     inst_i,
    input  logic [InstAddrBus-1:0] pc_i,
    output logic                   is_jal_o,
    output logic [InstAddrBus-1:0] target_o
);

    assign is_jal_o = (inst_i[6:0] == Opcode_jal);
    assign target_o = pc_i + jal_imm(inst_i);

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, single-outstanding imem handshake and the
// decode-facing output register. Optional JAL predecode via IF_JAL_PREDICT_EN.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] RESET_PC = RESET_PC_DEFAULT
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   jump_i,
    input  logic [InstAddrBus-1:0] jump_addr_i,
    output logic                   imem_req_o,
    output logic [InstAddrBus-1:0] imem_addr_o,
    input  logic                   imem_gnt_i,
    input  logic                   imem_rvalid_i,
    input  logic [InstBus-1:0]     imem_rdata_i,
    output logic [InstAddrBus-1:0] pc_o,
    output logic [InstBus-1:0]     inst_o,
    output logic                   ignore_o
);

    fetch_state_e           state_q, state_d;
    logic [InstAddrBus-1:0] pc_q, pc_d;
    logic [InstBus-1:0]     hold_q, hold_d;
    logic [InstAddrBus-1:0] out_pc_q, out_pc_d;
    logic [InstBus-1:0]     out_inst_q, out_inst_d;
    logic                   out_ign_q, out_ign_d;

    logic                   req;
    logic [InstAddrBus-1:0] addr;
    logic                   jump_take;
    logic [InstAddrBus-1:0] jump_tgt;
    logic [InstAddrBus-1:0] seq_pc;
    logic [InstAddrBus-1:0] next_fetch_pc;

    assign jump_take = jump_i && !stall_i;
    assign jump_tgt  = jump_addr_i & 32'hFFFF_FFFC;
    assign seq_pc    = pc_q + 32'd4;

`ifdef IF_JAL_PREDICT_EN
    logic [InstBus-1:0]     deliver_word;
    logic                   pd_is_jal;
    logic [InstAddrBus-1:0] pd_target;

    // The word being handed to decode comes from the bus or the hold buffer.
    assign deliver_word = (state_q == ST_HOLD) ? hold_q : imem_rdata_i;

    if_predecode u_predecode (
        .inst_i   (deliver_word),
        .pc_i     (pc_q),
        .is_jal_o (pd_is_jal),
        .target_o (pd_target)
    );

    assign next_fetch_pc = pd_is_jal ? pd_target : seq_pc;
`else
    assign next_fetch_pc = seq_pc;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_REQ;
            pc_q       <= RESET_PC;
            hold_q     <= NOP_INST;
            out_pc_q   <= '0;
            out_inst_q <= NOP_INST;
            out_ign_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            hold_q     <= hold_d;
            out_pc_q   <= out_pc_d;
            out_inst_q <= out_inst_d;
            out_ign_q  <= out_ign_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hold_d     = hold_q;
        out_pc_d   = out_pc_q;
        out_inst_d = out_inst_q;
        out_ign_d  = out_ign_q;
        req        = 1'b0;
        addr       = pc_q;

        // Unless a word completes below, an unstalled cycle presents a bubble.
        if (!stall_i) begin
            out_inst_d = NOP_INST;
            out_ign_d  = 1'b1;
        end

        case (state_q)
            ST_REQ: begin
                req = 1'b1;
                if (jump_take) begin
                    pc_d    = jump_tgt;
                    // A grant in the same cycle still owes us a stale response.
                    state_d = imem_gnt_i ? ST_DROP : ST_REQ;
                end else if (imem_gnt_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (jump_take) begin
                    pc_d    = jump_tgt;
                    state_d = imem_rvalid_i ? ST_REQ : ST_DROP;
                end else if (imem_rvalid_i) begin
                    if (stall_i) begin
                        hold_d  = imem_rdata_i;
                        state_d = ST_HOLD;
                    end else begin
                        out_pc_d   = seq_pc;
                        out_inst_d = imem_rdata_i;
                        out_ign_d  = 1'b0;
                        pc_d       = next_fetch_pc;
                        req        = 1'b1;
                        addr       = next_fetch_pc;
                        state_d    = imem_gnt_i ? ST_WAIT : ST_REQ;
                    end
                end
            end
            ST_HOLD: begin
                if (!stall_i) begin
                    if (jump_take) begin
                        pc_d = jump_tgt;
                    end else begin
                        out_pc_d   = seq_pc;
                        out_inst_d = hold_q;
                        out_ign_d  = 1'b0;
                        pc_d       = next_fetch_pc;
                    end
                    state_d = ST_REQ;
                end
            end
            ST_DROP: begin
                if (jump_take) begin
                    pc_d = jump_tgt;
                end
                if (imem_rvalid_i) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase
    end

    assign imem_req_o  = req && !rst;
    assign imem_addr_o = addr;
    assign pc_o        = out_pc_q;
    assign inst_o      = out_inst_q;
    assign ignore_o    = out_ign_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios plus a randomized run, scored against
// a program-flow model (expected fetch address sequence and memory contents).
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        jump_i;
    logic [31:0] jump_addr_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        ignore_o;

    if_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .jump_i        (jump_i),
        .jump_addr_i   (jump_addr_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .pc_o          (pc_o),
        .inst_o        (inst_o),
        .ignore_o      (ignore_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] valid_log[$];

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          last_valid_cyc = 0;
    int          addr8_cycles = 0;
    int          gnt_block_cnt = 0;
    logic [31:0] gnt_block_addr = 32'hFFFF_FFFF;
    logic [31:0] stall_addr = 32'hFFFF_FFFF;
    int          stall_left = 0;
    logic        chk_noreq = 1'b0;

    logic        p_rst = 1'b0, p_stall = 1'b0, p_jump = 1'b0, p_reqwait = 1'b0;
    logic [31:0] p_addr = '0, s_pc = '0, s_inst = '0;
    logic        s_ign = 1'b0;
    logic [31:0] exp_addr = '0;

    // Memory image: each word holds its own address, except a JAL at 0x20
    // (imm = +16) when predecode is built in.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
`ifdef IF_JAL_PREDICT_EN
        if (a == 32'h20) return 32'h0100_006F;
`endif
        return a;
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [31:0] w);
`ifdef IF_JAL_PREDICT_EN
        if (w[6:0] == 7'h6F)
            return a + {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
`endif
        return a + (w & 32'h0) + 32'd4;
    endfunction

    function automatic int find_addr(input logic [31:0] a);
        foreach (valid_log[i]) if (valid_log[i] == a) return i;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; stall_i = 1'b0; jump_i = 1'b0; jump_addr_i = '0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        pend.delete(); valid_log.delete();
        addr8_cycles = 0; stall_left = 0; chk_noreq = 1'b0;
        @(negedge clk);
        cyc++;
        chk("req_in_reset", {31'b0, imem_req_o}, 32'd0);
        p_rst = 1'b1; p_reqwait = 1'b0; exp_addr = 32'h0; last_valid_cyc = cyc;
    endtask

    // One clock cycle: score the output register, drive inputs, act as memory.
    task automatic step(input logic st, input logic jp, input logic [31:0] ja,
                        input int gnt_pct, input int dly_max);
        logic g;
        logic take;
        @(negedge clk);
        cyc++;
        if (p_rst) begin
            chk("rst_pc_o", pc_o, 32'd0);
            chk("rst_inst_o", inst_o, 32'd0);
            chk("rst_ignore_o", {31'b0, ignore_o}, 32'd1);
        end else if (p_stall) begin
            chk("stall_pc_o", pc_o, s_pc);
            chk("stall_inst_o", inst_o, s_inst);
            chk("stall_ignore_o", {31'b0, ignore_o}, {31'b0, s_ign});
        end else if (p_jump) begin
            chk("jump_bubble_ignore", {31'b0, ignore_o}, 32'd1);
            chk("jump_bubble_inst", inst_o, 32'd0);
        end else if (ignore_o === 1'b1) begin
            chk("bubble_inst", inst_o, 32'd0);
        end else begin
            chk("valid_pc_o", pc_o, exp_addr + 32'd4);
            chk("valid_inst_o", inst_o, mem_word(exp_addr));
            $display("cyc=%0d deliver pc_o=%h inst_o=%h", cyc, pc_o, inst_o);
            valid_log.push_back(exp_addr);
            last_valid_cyc = cyc;
            exp_addr = next_addr(exp_addr, mem_word(exp_addr));
        end
        if (cyc - last_valid_cyc > 100) begin
            total++; bad++;
            $error("FAIL progress observed=%0d idle cycles expected<=100", cyc - last_valid_cyc);
            last_valid_cyc = cyc;
        end

        rst = 1'b0; jump_i = jp; jump_addr_i = ja; stall_i = st;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(pend[0].addr);
            if (pend[0].addr == stall_addr) stall_left = 2;
            void'(pend.pop_front());
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
        end
        if (stall_left > 0) begin
            stall_i = 1'b1;
            stall_left--;
        end
        #1;
        if (chk_noreq) begin
            chk("drop_no_req", {31'b0, imem_req_o}, 32'd0);
            chk_noreq = 1'b0;
        end
        if (p_reqwait) begin
            chk("req_held", {31'b0, imem_req_o}, 32'd1);
            chk("addr_held", imem_addr_o, p_addr);
        end
        if (imem_req_o === 1'b1 && imem_addr_o == 32'h8) addr8_cycles++;
        g = (imem_req_o === 1'b1) && ($urandom_range(99) < gnt_pct);
        if (g && gnt_block_cnt > 0 && imem_addr_o == gnt_block_addr) begin
            g = 1'b0;
            gnt_block_cnt--;
        end
        imem_gnt_i = g;
        if (g) begin
            chk("one_outstanding", pend.size(), 32'd0);
            pend.push_back('{imem_addr_o, cyc + $urandom_range(dly_max, 1)});
        end
        take      = jp && !stall_i;
        p_reqwait = (imem_req_o === 1'b1) && !g && !take;
        p_addr    = imem_addr_o;
        p_rst     = 1'b0;
        p_stall   = stall_i;
        p_jump    = take;
        s_pc      = pc_o;
        s_inst    = inst_o;
        s_ign     = ignore_o;
        if (take) exp_addr = ja & 32'hFFFF_FFFC;
    endtask

    initial begin
        int idx;
        int sz;
        rst = 1'b1; stall_i = 1'b0; jump_i = 1'b0; jump_addr_i = '0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;

        // Zero-wait memory: first word two checks after release, then one per cycle.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 100, 1);
        chk("zw_count", valid_log.size(), 32'd8);
        chk("zw_last", valid_log.size() > 0 ? valid_log[$] : 32'hDEAD_BEEF, 32'd28);

        // Grant withheld three cycles on address 8.
        do_reset();
        gnt_block_addr = 32'h8; gnt_block_cnt = 3;
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 32'h0, 100, 1);
        chk("gnt_delay_addr8_cycles", addr8_cycles, 32'd4);
        chk("gnt_delay_count", valid_log.size(), 32'd11);
        gnt_block_addr = 32'hFFFF_FFFF;

        // Stall for two cycles as the response for address 12 arrives.
        do_reset();
        stall_addr = 32'hC;
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 32'h0, 100, 1);
        stall_addr = 32'hFFFF_FFFF;
        idx = find_addr(32'hC);
        chk("stall_next_after_12",
            (idx >= 0 && idx + 1 < valid_log.size()) ? valid_log[idx+1] : 32'hDEAD_BEEF, 32'h10);

        // Redirect while waiting on a slow response.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if (valid_log.size() >= 2 && pend.size() > 0 && pend[0].due > cyc + 1) break;
            step(1'b0, 1'b0, 32'h0, 100, 3);
        end
        sz = valid_log.size();
        step(1'b0, 1'b1, 32'h100, 100, 3);
        chk_noreq = 1'b1;
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 32'h0, 100, 3);
        chk("jump_target_first",
            (valid_log.size() > sz) ? valid_log[sz] : 32'hDEAD_BEEF, 32'h100);

        // PC wrap at the top of the address space.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 100, 1);
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 100, 1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 100, 1);
        idx = find_addr(32'hFFFF_FFFC);
        chk("wrap_next",
            (idx >= 0 && idx + 1 < valid_log.size()) ? valid_log[idx+1] : 32'hDEAD_BEEF, 32'h0);

`ifdef IF_JAL_PREDICT_EN
        // JAL +16 at 0x20 redirects fetch to 0x30 without jump_i.
        do_reset();
        for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 32'h0, 100, 1);
        idx = find_addr(32'h20);
        chk("jal_predict_next",
            (idx >= 0 && idx + 1 < valid_log.size()) ? valid_log[idx+1] : 32'hDEAD_BEEF, 32'h30);
`endif

        // Randomized stalls, redirects, grant and response latency.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(99) < 15, $urandom_range(99) < 4, $urandom, 60, 4);
        end
        chk("random_made_progress", {31'b0, valid_log.size() > 200}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage: owns the program counter, issues word fetches to instruction memory over a request/grant/response handshake, and presents each fetched instruction together with its pc+4 value to the decode stage through its own output register. Taken jumps/branches resolved in decode redirect the PC and squash the wrong-path instruction. Sits directly upstream of `id` and feeds its `pc_i`, `inst_i` and `ignore_i`.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall_i` in 1: pipeline stall from hazard control; freeze PC and output register.
- `jump_i` in 1: taken control transfer from decode (`jump_o`).
- `jump_addr_i` in 32: redirect target (`jump_addr_o`).
- `imem_req_o` out 1: fetch request valid.
- `imem_addr_o` out 32: fetch address (word aligned).
- `imem_gnt_i` in 1: request accepted this cycle.
- `imem_rvalid_i` in 1: response data valid.
- `imem_rdata_i` in 32: instruction word.
- `pc_o` out 32: fetch address + 4 of the presented instruction (decode `pc_i`).
- `inst_o` out 32: presented instruction; 32'h0 when invalid.
- `ignore_o` out 1: presented slot is a bubble/squashed; decode must not act on it.

## Operation
- At most one outstanding memory request. States: REQ, WAIT, HOLD, DROP.
- REQ: `imem_req_o`=1, `imem_addr_o`=pc. On `imem_gnt_i` go WAIT. On `jump_i` (before grant): pc<=jump_addr_i, stay REQ.
- WAIT: on `imem_rvalid_i` with `stall_i`=0 and `jump_i`=0: load output register {pc+4, rdata, ignore=0}, pc<=pc+4, and assert `imem_req_o` for pc+4 in the same cycle (gnt -> stay WAIT, else REQ). With `stall_i`=1: capture rdata into hold buffer, go HOLD.
- HOLD: when `stall_i` drops, load output register from hold buffer, pc<=pc+4, go REQ.
- `jump_i`=1 (only honoured when `stall_i`=0; ignored while stalled): pc<=jump_addr_i; output register loads bubble {inst=0, ignore=1} next edge; hold buffer discarded. From WAIT without rvalid that cycle -> DROP. From WAIT with rvalid same cycle -> data discarded, go REQ. From HOLD -> REQ.
- DROP: no request; discard the next `imem_rvalid_i`, then REQ at redirected pc. A second `jump_i` while in DROP just overwrites pc.
- Output register holds value while `stall_i`=1; when no fetch completes and not stalled, loads bubble.
- pc arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0. `jump_addr_i[1:0]` forced to 0.

## Timing
- Reset: pc=RESET_PC, state=REQ, `imem_req_o`=0 during reset cycle, `pc_o`=0, `inst_o`=0, `ignore_o`=1.
- First request in cycle after reset deasserts.
- With gnt same cycle as req and rvalid one cycle later: first instruction at `inst_o` 3 cycles after reset release, then 1 instruction/cycle.
- Redirect penalty (zero-wait memory): jump_i at edge N -> bubble presented at N+1, target instruction at N+3.
- `imem_req_o`/`imem_addr_o` stable until gnt.

## Configuration
- `IF_JAL_PREDICT_EN`: defined -> fetch predecodes each accepted word; opcode 7'b1101111 (JAL) redirects pc to fetch_addr + J-imm immediately, presented instruction still delivered normally; decode's later `jump_i` for that JAL to the same target must be suppressed by decode, so fetch asserts nothing new. Not defined -> no predecode; JAL handled only through `jump_i`.

## Structure
- Shared package: state encoding, `RESET_PC` default, opcode constants (`Opcode_jal`), NOP word (32'h0), `InstAddrBus`/`InstBus` widths.
- Optional sub-module `if_predecode` (combinational JAL detect + target) instantiated only under `IF_JAL_PREDICT_EN`.

## Test plan
- Reset then zero-wait memory returning addr as data -> `inst_o` sequence 0,4,8,... with `pc_o` 4,8,12, one per cycle, `ignore_o`=0.
- gnt delayed 3 cycles on addr 8 -> `imem_addr_o` holds 8 for 4 cycles, no duplicate or skipped instruction.
- stall_i high 2 cycles while rvalid arrives for addr 12 -> `inst_o` frozen, word 12 presented after stall drops, then 16.
- jump_i with jump_addr_i=32'h100 while WAIT and rvalid late -> DROP, stale word discarded, bubble (`ignore_o`=1, `inst_o`=0), next valid `pc_o`=32'h104.
- pc at 32'hFFFF_FFFC -> next fetch address 0.
- With `IF_JAL_PREDICT_EN`, JAL imm=+16 at addr 0x20 -> next `imem_addr_o`=0x30, no jump_i needed.
